// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared sizing for the alignment/normalisation shifter: single and double precision defaults.
// Pure constants and a latency helper; no logic, no backpressure.
package barrel_shifter_pipe_pkg;

    localparam int          SP_SWR       = 26;
    localparam int          SP_EWR       = 5;
    localparam logic [4:0]  SP_PIPE_MASK = 5'b00101;

    localparam int          DP_SWR       = 55;
    localparam int          DP_EWR       = 6;
    localparam logic [5:0]  DP_PIPE_MASK = 6'b000101;

    // Output register is always present, hence the +1.
    function automatic int pipe_latency(input logic [31:0] mask);
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            n += int'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result bundle of the shifter; master drives operands and stall, slave returns results.
// No handshake beyond valid qualifiers and a global stall.
interface barrel_shifter_pipe_if
    import barrel_shifter_pipe_pkg::*;
#(
    parameter int SWR = SP_SWR,
    parameter int EWR = SP_EWR
);
    logic           stall_i;
    logic           valid_i;
    logic [SWR-1:0] Data_i;
    logic [EWR-1:0] Shift_Value_i;
    logic           Left_Right_i;
    logic           Bit_Shift_i;
    logic           valid_o;
    logic [SWR-1:0] Data_o;
    logic           Sticky_o;

    modport master (
        output stall_i, valid_i, Data_i, Shift_Value_i, Left_Right_i, Bit_Shift_i,
        input  valid_o, Data_o, Sticky_o
    );

    modport slave (
        input  stall_i, valid_i, Data_i, Shift_Value_i, Left_Right_i, Bit_Shift_i,
        output valid_o, Data_o, Sticky_o
    );
endinterface

// File: rtl/barrel_shifter_pipe_shift_level_stage.sv
// One right-shift level by 2^LEVEL with fill and sticky; latency REG (0 or 1) cycles.
// stall holds the optional register; no other backpressure.
module shift_level_stage #(
    parameter int SWR   = 26,
    parameter int EWR   = 5,
    parameter int LEVEL = 0,
    parameter bit REG   = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic [SWR-1:0] prev_data,
    input  logic           prev_sticky,
    input  logic           prev_valid,
    input  logic [EWR-1:0] prev_shift,
    input  logic           prev_dir,
    input  logic           prev_fill,
    output logic [SWR-1:0] next_data,
    output logic           next_sticky,
    output logic           next_valid,
    output logic [EWR-1:0] next_shift,
    output logic           next_dir,
    output logic           next_fill
);
    localparam int             STEP      = 1 << LEVEL;
    localparam logic [SWR-1:0] ALL_ONES  = '1;
    localparam logic [SWR-1:0] FILL_MASK = ~(ALL_ONES >> STEP);
    localparam logic [SWR-1:0] DROP_MASK = ~(ALL_ONES << STEP);
    localparam logic [EWR-1:0] LOW_BITS  = EWR'((1 << LEVEL) - 1);

    logic [SWR-1:0] shifted;
    logic [SWR-1:0] orig_mask;
    logic           dropped;

    // Lower levels have already pushed prev_shift[LEVEL-1:0] fill bits in at the
    // top, so only positions below SWR minus that amount still hold original data.
    always_comb begin
        orig_mask = ALL_ONES >> (prev_shift & LOW_BITS);
        shifted   = prev_data;
        dropped   = 1'b0;
        if (prev_shift[LEVEL]) begin
            shifted = (prev_data >> STEP) | (prev_fill ? FILL_MASK : '0);
            dropped = |(prev_data & DROP_MASK & orig_mask);
        end
    end

    generate
        if (REG) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    next_data   <= '0;
                    next_sticky <= 1'b0;
                    next_valid  <= 1'b0;
                    next_shift  <= '0;
                    next_dir    <= 1'b0;
                    next_fill   <= 1'b0;
                end else if (!stall) begin
                    next_data   <= shifted;
                    next_sticky <= prev_sticky | dropped;
                    next_valid  <= prev_valid;
                    next_shift  <= prev_shift;
                    next_dir    <= prev_dir;
                    next_fill   <= prev_fill;
                end
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst, stall};
            assign next_data   = shifted;
            assign next_sticky = prev_sticky | dropped;
            assign next_valid  = prev_valid;
            assign next_shift  = prev_shift;
            assign next_dir    = prev_dir;
            assign next_fill   = prev_fill;
        end
    endgenerate

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log barrel shifter (right/left, fill bit, right-shift sticky); latency 1+popcount(PIPE_MASK).
// stall_i freezes every stage including the output register; operands offered during stall are dropped.
module barrel_shifter_pipe
    import barrel_shifter_pipe_pkg::*;
#(
    parameter int             SWR       = SP_SWR,
    parameter int             EWR       = SP_EWR,
    parameter logic [EWR-1:0] PIPE_MASK = SP_PIPE_MASK
) (
    input  logic                  clk,
    input  logic                  rst,
    barrel_shifter_pipe_if.slave  bus
);
    logic [SWR-1:0] lvl_data   [0:EWR];
    logic           lvl_sticky [0:EWR];
    logic           lvl_valid  [0:EWR];
    logic [EWR-1:0] lvl_shift  [0:EWR];
    logic           lvl_dir    [0:EWR];
    logic           lvl_fill   [0:EWR];

    logic [SWR-1:0] in_rev;
    logic [SWR-1:0] out_rev;
    logic [SWR-1:0] out_data;
    logic           out_sticky;

    logic           valid_q;
    logic [SWR-1:0] data_q;
    logic           sticky_q;

    // Left shifts reuse the right-shift levels on bit-reversed data.
    for (genvar j = 0; j < SWR; j++) begin : g_rev
        assign in_rev[j]  = bus.Data_i[SWR-1-j];
        assign out_rev[j] = lvl_data[EWR][SWR-1-j];
    end

    assign lvl_data[0]   = bus.Left_Right_i ? in_rev : bus.Data_i;
    assign lvl_sticky[0] = 1'b0;
    assign lvl_valid[0]  = bus.valid_i & ~bus.stall_i;
    assign lvl_shift[0]  = bus.Shift_Value_i;
    assign lvl_dir[0]    = bus.Left_Right_i;
    assign lvl_fill[0]   = bus.Bit_Shift_i;

    for (genvar k = 0; k < EWR; k++) begin : g_lvl
        shift_level_stage #(
            .SWR   (SWR),
            .EWR   (EWR),
            .LEVEL (k),
            .REG   (PIPE_MASK[k])
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .stall       (bus.stall_i),
            .prev_data   (lvl_data[k]),
            .prev_sticky (lvl_sticky[k]),
            .prev_valid  (lvl_valid[k]),
            .prev_shift  (lvl_shift[k]),
            .prev_dir    (lvl_dir[k]),
            .prev_fill   (lvl_fill[k]),
            .next_data   (lvl_data[k+1]),
            .next_sticky (lvl_sticky[k+1]),
            .next_valid  (lvl_valid[k+1]),
            .next_shift  (lvl_shift[k+1]),
            .next_dir    (lvl_dir[k+1]),
            .next_fill   (lvl_fill[k+1])
        );
    end

    logic unused_tail;
    assign unused_tail = &{1'b0, lvl_shift[EWR], lvl_fill[EWR]};

    // Bits leaving a left shift are not rounding information.
    assign out_data   = lvl_dir[EWR] ? out_rev : lvl_data[EWR];
    assign out_sticky = lvl_sticky[EWR] & ~lvl_dir[EWR];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            sticky_q <= 1'b0;
        end else if (!bus.stall_i) begin
            valid_q  <= lvl_valid[EWR];
            data_q   <= out_data;
            sticky_q <= out_sticky;
        end
    end

    assign bus.valid_o  = valid_q;
    assign bus.Data_o   = data_q;
    assign bus.Sticky_o = sticky_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at default sizing: vector table plus streaming, stall and reset sequences.
module tb_barrel_shifter_pipe;

    localparam int SWR = 26;
    localparam int EWR = 5;

    logic clk;
    logic rst;

    barrel_shifter_pipe_if #(.SWR(SWR), .EWR(EWR)) bus();

    barrel_shifter_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [SWR-1:0] data;
        logic [EWR-1:0] sh;
        logic           left;
        logic           fill;
        logic [SWR-1:0] exp_data;
        logic           exp_sticky;
    } vec_t;

    vec_t vecs[12];
    int   n_checks;
    int   n_fail;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [SWR-1:0] act, input logic [SWR-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [SWR-1:0] d, input logic [EWR-1:0] s,
                            input logic left, input logic fill);
        bus.valid_i       = 1'b1;
        bus.Data_i        = d;
        bus.Shift_Value_i = s;
        bus.Left_Right_i  = left;
        bus.Bit_Shift_i   = fill;
    endtask

    task automatic idle_op();
        bus.valid_i       = 1'b0;
        bus.Data_i        = 26'h155AAAA;
        bus.Shift_Value_i = 5'd7;
        bus.Left_Right_i  = 1'b0;
        bus.Bit_Shift_i   = 1'b1;
    endtask

    // Offer at negedge N, sampled at the next posedge; result visible after the third posedge.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_op(v.data, v.sh, v.left, v.fill);
        @(negedge clk);
        idle_op();
        @(negedge clk);
        check_bit({v.name, ".early_valid"}, bus.valid_o, 1'b0);
        @(negedge clk);
        check_bit({v.name, ".valid"}, bus.valid_o, 1'b1);
        check_data({v.name, ".data"}, bus.Data_o, v.exp_data);
        check_bit({v.name, ".sticky"}, bus.Sticky_o, v.exp_sticky);
    endtask

    initial begin
        logic [SWR-1:0] held;
        int             seen;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"r_ff_s4",      26'h00000FF, 5'd4,  1'b0, 1'b0, 26'h000000F, 1'b1};
        vecs[1]  = '{"l_1_s3_f0",    26'h0000001, 5'd3,  1'b1, 1'b0, 26'h0000008, 1'b0};
        vecs[2]  = '{"l_1_s3_f1",    26'h0000001, 5'd3,  1'b1, 1'b1, 26'h000000F, 1'b0};
        vecs[3]  = '{"r_over_msb",   26'h2000000, 5'd31, 1'b0, 1'b1, 26'h3FFFFFF, 1'b1};
        vecs[4]  = '{"r_over_zero",  26'h0000000, 5'd31, 1'b0, 1'b1, 26'h3FFFFFF, 1'b0};
        vecs[5]  = '{"r_s0",         26'h0000123, 5'd0,  1'b0, 1'b1, 26'h0000123, 1'b0};
        vecs[6]  = '{"r_s26",        26'h3FFFFFF, 5'd26, 1'b0, 1'b0, 26'h0000000, 1'b1};
        vecs[7]  = '{"l_ones_s25",   26'h3FFFFFF, 5'd25, 1'b1, 1'b0, 26'h2000000, 1'b0};
        vecs[8]  = '{"r_10_s4_f1",   26'h0000010, 5'd4,  1'b0, 1'b1, 26'h3C00001, 1'b0};
        vecs[9]  = '{"l_msb_out",    26'h2000000, 5'd1,  1'b1, 1'b0, 26'h0000000, 1'b0};
        vecs[10] = '{"r_8_s3",       26'h0000008, 5'd3,  1'b0, 1'b0, 26'h0000001, 1'b0};
        vecs[11] = '{"r_8_s4",       26'h0000008, 5'd4,  1'b0, 1'b0, 26'h0000000, 1'b1};

        rst         = 1'b0;
        bus.stall_i = 1'b0;
        idle_op();
        repeat (2) @(negedge clk);
        check_bit("reset.valid", bus.valid_o, 1'b0);
        check_data("reset.data", bus.Data_o, '0);
        check_bit("reset.sticky", bus.Sticky_o, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Streaming: three back-to-back right shifts of all-ones.
        @(negedge clk);
        drive_op(26'h3FFFFFF, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive_op(26'h3FFFFFF, 5'd2, 1'b0, 1'b0);
        @(negedge clk);
        drive_op(26'h3FFFFFF, 5'd25, 1'b0, 1'b0);
        @(negedge clk);
        idle_op();
        check_bit("stream0.valid", bus.valid_o, 1'b1);
        check_data("stream0.data", bus.Data_o, 26'h1FFFFFF);
        check_bit("stream0.sticky", bus.Sticky_o, 1'b1);
        @(negedge clk);
        check_bit("stream1.valid", bus.valid_o, 1'b1);
        check_data("stream1.data", bus.Data_o, 26'h0FFFFFF);
        check_bit("stream1.sticky", bus.Sticky_o, 1'b1);
        @(negedge clk);
        check_bit("stream2.valid", bus.valid_o, 1'b1);
        check_data("stream2.data", bus.Data_o, 26'h0000001);
        check_bit("stream2.sticky", bus.Sticky_o, 1'b1);
        @(negedge clk);
        check_bit("stream.tail_valid", bus.valid_o, 1'b0);

        // Stall: A at output, B one stage behind, freeze 4 cycles, junk offered meanwhile.
        @(negedge clk);
        drive_op(26'h00000FF, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        drive_op(26'h0000001, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        idle_op();
        @(negedge clk);
        check_bit("stall.a_valid", bus.valid_o, 1'b1);
        check_data("stall.a_data", bus.Data_o, 26'h000000F);
        bus.stall_i = 1'b1;
        drive_op(26'h1234567, 5'd2, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_bit("stall.hold_valid", bus.valid_o, 1'b1);
            check_data("stall.hold_data", bus.Data_o, 26'h000000F);
            check_bit("stall.hold_sticky", bus.Sticky_o, 1'b1);
        end
        bus.stall_i = 1'b0;
        idle_op();
        @(negedge clk);
        check_bit("stall.b_valid", bus.valid_o, 1'b1);
        check_data("stall.b_data", bus.Data_o, 26'h000000F);
        check_bit("stall.b_sticky", bus.Sticky_o, 1'b0);
        @(negedge clk);
        check_bit("stall.no_junk", bus.valid_o, 1'b0);
        @(negedge clk);
        check_bit("stall.no_junk2", bus.valid_o, 1'b0);

        // Asynchronous reset with one result at the output and one in flight.
        @(negedge clk);
        drive_op(26'h00000FF, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        drive_op(26'h3FFFFFF, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        idle_op();
        @(negedge clk);
        check_bit("rstmid.pre_valid", bus.valid_o, 1'b1);
        held = bus.Data_o;
        check_data("rstmid.pre_data", held, 26'h000000F);
        #2 rst = 1'b0;
        #1;
        check_bit("rstmid.valid", bus.valid_o, 1'b0);
        check_data("rstmid.data", bus.Data_o, '0);
        check_bit("rstmid.sticky", bus.Sticky_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstmid.stale: got %0d valid cycles expected 0", seen);
        end

        vecs[0].name = "post_reset";
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined logarithmic barrel shifter for the add/subtract datapath, used for significand alignment (right shift) and post-normalisation (left shift). It is built from EWR shift levels; level k shifts by 2^k. A per-level mask inserts pipeline registers between levels. It adds three things a single shift level lacks: a direction select, a programmable fill bit, and a sticky bit that collects the bits shifted out on right shifts for rounding.

## Interface
Parameters:
- SWR, 26: significand/data width in bits.
- EWR, 5: shift-amount width; number of shift levels. 2^EWR-1 must be >= SWR-1.
- PIPE_MASK, 5'b00101: EWR bits. Bit k=1 puts a register stage after level k.

Ports:
- clk: input, 1. Single clock; all state on rising edge.
- rst: input, 1. Asynchronous, active-low reset.
- stall_i: input, 1. 1 = every register stage holds its contents.
- valid_i: input, 1. Qualifies the operands on this cycle.
- Data_i: input, SWR. Operand to shift.
- Shift_Value_i: input, EWR. Shift amount, 0..2^EWR-1.
- Left_Right_i: input, 1. 1 = left shift, 0 = right shift.
- Bit_Shift_i: input, 1. Fill bit written into vacated positions.
- valid_o: output, 1. Qualifies Data_o and Sticky_o.
- Data_o: output, SWR. Shifted result.
- Sticky_o: output, 1. OR of the original data bits shifted out. Right shift only.

## Operation
- Left shift uses bit reversal: reverse Data_i, apply the right-shift levels, then reverse the result. Shift_Value_i, the direction bit and the fill bit travel with the data through every stage.
- Level k: if Shift_Value_i[k]=1, out[j] = in[j+2^k] when j+2^k <= SWR-1, otherwise out[j] = fill. If the bit is 0, data passes through unchanged.
- Right shift, amount s:
  - Data_o = Data_i >> s, with the top min(s,SWR) bits equal to Bit_Shift_i.
  - Sticky_o = OR of Data_i[min(s,SWR)-1:0]. Fill bits never contribute. s=0 gives Sticky_o=0.
- Left shift, amount s: Data_o = Data_i << s, with the low min(s,SWR) bits equal to Bit_Shift_i. Sticky_o=0.
- s >= SWR: Data_o is all fill bits. On a right shift, Sticky_o = |Data_i.
- Sticky is accumulated per level as an OR of the bits dropped at the LSB end, masked so fill bits are excluded. The accumulator is carried through the pipeline registers.
- No backpressure beyond stall_i. While stall_i=1, valid_i is ignored and no operand is accepted.

## Timing
- Latency = 1 + popcount(PIPE_MASK) cycles, from the clk edge that samples valid_i=1 to the cycle valid_o=1. The output register is always present. Default latency is 3.
- Throughput is one operation per cycle while stall_i=0. Back-to-back operands emerge on consecutive cycles, in order.
- Reset, asserted at any time including mid-flight: all stage registers, valid_o, Data_o and Sticky_o go to 0 immediately. In-flight operations are discarded. The first capture happens on the first rising edge after rst deasserts.
- stall_i=1: all stages, including the output register, hold. valid_o holds its value. Outputs are stable for the whole stall.
- Bubbles (valid_i=0) propagate as valid=0. Data registers may still load, but downstream logic must ignore them.

## Structure
- Shared package/header holds the default SWR, EWR and PIPE_MASK for single and double precision (SWR=26/55, EWR=5/6).
- Sub-module shift_level_stage:
  - One right-shift level by 2^LEVEL, with fill and the sticky contribution.
  - Followed by an optional register, selected by a REG parameter. The register carries data, sticky, valid, remaining shift bits, direction and fill.
- Top level: the input reversal mux, a generate loop of EWR shift_level_stage instances, the output reversal mux, and the output register.

## Test plan
Default parameters; latency 3 in every scenario.
- Right shift:
  - Stimulus: Data_i=26'h00000FF, s=4, R, fill 0, valid_i=1.
  - Response: 3 cycles later, valid_o=1, Data_o=26'h000000F, Sticky_o=1.
- Left shift:
  - Stimulus: Data_i=26'h0000001, s=3, L, fill 0.
  - Response: Data_o=26'h0000008, Sticky_o=0.
  - Repeat with fill 1: Data_o=26'h000000F.
- Overshift:
  - Stimulus: Data_i=26'h2000000, s=31, R, fill 1.
  - Response: Data_o=26'h3FFFFFF, Sticky_o=1.
  - Repeat with Data_i=0, fill 1: Sticky_o=0.
- Streaming:
  - Stimulus: 3 back-to-back operations, right shift of 26'h3FFFFFF by s=1, 2, 25.
  - Response: valid_o=1 on 3 consecutive cycles, Data_o = 26'h1FFFFFF, 26'h0FFFFFF, 26'h0000001, in order, each with Sticky_o=1.
- Stall:
  - Stimulus: assert stall_i for 4 cycles while 2 operations are in flight.
  - Response: outputs frozen for those 4 cycles. Results emerge exactly 4 cycles late, unchanged and in order.
- Reset mid-flight:
  - Stimulus: drive rst=0 asynchronously with 2 operations in flight.
  - Response: valid_o, Data_o and Sticky_o are 0 immediately. No stale result appears after rst returns high.
